// File: rtl/conv_window_seq_if.sv
// ----------------------------------------------------------------------------
// conv_window_seq_if
// Bundle between the convolution window sequencer and its surroundings:
// the layer-controller handshake, the image RAM / kernel ROM read ports,
// the MAC controls and the output RAM write port.
//
// Modports
//   master : layer controller / memory side (drives start, hold, abort)
//   slave  : conv_window_seq (drives everything else)
//
// Signals
//   start      one-cycle request to run a full layer pass
//   hold       freeze request
//   abort      cancel a pass in progress
//   busy       sequencer is not idle
//   done       one-cycle pulse on pass completion
//   img_rd     image RAM read strobe,  img_addr  [ADDR_W-1:0]
//   kern_rd    kernel ROM read strobe, kern_addr [KADDR_W-1:0]
//   mac_clr    accumulator clear pulse
//   mac_en     accumulate enable, aligned with returned read data
//   out_wr     output RAM write strobe, out_addr [ADDR_W-1:0]
// ----------------------------------------------------------------------------
interface conv_window_seq_if #(
    parameter int ADDR_W  = 10,
    parameter int KADDR_W = 4
);
    logic               start;
    logic               hold;
    logic               abort;
    logic               busy;
    logic               done;
    logic               img_rd;
    logic [ADDR_W-1:0]  img_addr;
    logic               kern_rd;
    logic [KADDR_W-1:0] kern_addr;
    logic               mac_clr;
    logic               mac_en;
    logic               out_wr;
    logic [ADDR_W-1:0]  out_addr;

    modport master (
        output start, hold, abort,
        input  busy, done, img_rd, img_addr, kern_rd, kern_addr,
               mac_clr, mac_en, out_wr, out_addr
    );

    modport slave (
        input  start, hold, abort,
        output busy, done, img_rd, img_addr, kern_rd, kern_addr,
               mac_clr, mac_en, out_wr, out_addr
    );
endinterface

// File: rtl/conv_window_seq.sv
// ----------------------------------------------------------------------------
// conv_window_seq
// Sequencer for a valid-mode KxK convolution over an IMG_W x IMG_H feature
// map. For every output pixel it clears the MAC, streams the K*K image and
// kernel reads, waits one cycle for the last read to return, and writes the
// result. Output pixels are produced in raster order.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      conv_window_seq_if.slave (handshake, memory ports, MAC controls)
//
// State table
//   state   | meaning
//   IDLE    | waiting for start (blocked while hold is high)
//   CLR     | mac_clr pulse for the next output pixel
//   RUN     | one image/kernel read per cycle, kc fastest, K*K reads
//   FLUSH   | last read data returning, no strobes
//   WRITE   | out_wr at row*OUT_W+col, advance col/row
//   DONE    | done pulse, back to IDLE
// ----------------------------------------------------------------------------
module conv_window_seq #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int K       = 3,
    parameter int ADDR_W  = 10,
    parameter int KADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    conv_window_seq_if.slave  bus
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;

    localparam logic [KADDR_W-1:0] K_LAST   = KADDR_W'(K - 1);
    localparam logic [KADDR_W-1:0] K_A      = KADDR_W'(K);
    localparam logic [ADDR_W-1:0]  COL_LAST = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0]  ROW_LAST = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0]  IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]  OUT_W_A  = ADDR_W'(OUT_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_FLUSH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_row;
    logic [ADDR_W-1:0]   r_col;
    logic [KADDR_W-1:0]  r_kr;
    logic [KADDR_W-1:0]  r_kc;
    logic                r_mac_en;

    logic                w_abort;
    logic                w_last_tap;
    logic                w_last_pix;

    logic                w_busy;
    logic                w_done;
    logic                w_img_rd;
    logic                w_kern_rd;
    logic                w_mac_clr;
    logic                w_out_wr;
    logic [ADDR_W-1:0]   w_img_addr;
    logic [KADDR_W-1:0]  w_kern_addr;
    logic [ADDR_W-1:0]   w_out_addr;

    // Abort is meaningless in IDLE; qualifying it here keeps IDLE start
    // handling independent of a stray abort level.
    assign w_abort    = bus.abort && (r_state != S_IDLE);
    assign w_last_tap = (r_kr == K_LAST) && (r_kc == K_LAST);
    assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: abort beats hold, hold freezes everything else
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else if (!bus.hold) begin
            case (r_state)
                S_IDLE:  if (bus.start) w_next = S_CLR;
                S_CLR:   w_next = S_RUN;
                S_RUN:   if (w_last_tap) w_next = S_FLUSH;
                S_FLUSH: w_next = S_WRITE;
                S_WRITE: w_next = w_last_pix ? S_DONE : S_CLR;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window / pixel counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row <= '0;
            r_col <= '0;
            r_kr  <= '0;
            r_kc  <= '0;
        end else if (!w_abort && !bus.hold) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_row <= '0;
                        r_col <= '0;
                        r_kr  <= '0;
                        r_kc  <= '0;
                    end
                end
                S_RUN: begin
                    // Both tap counters wrap on the last read, so the next
                    // window starts from kr=kc=0 without an extra clear.
                    if (r_kc == K_LAST) begin
                        r_kc <= '0;
                        r_kr <= (r_kr == K_LAST) ? '0 : r_kr + 1'b1;
                    end else begin
                        r_kc <= r_kc + 1'b1;
                    end
                end
                S_WRITE: begin
                    // The final pixel position is left in place so the
                    // counters still show where the pass ended.
                    if (!w_last_pix) begin
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode: strobes come from registered state, only hold gates
    // them combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_done    = 1'b0;
        w_img_rd  = 1'b0;
        w_kern_rd = 1'b0;
        w_mac_clr = 1'b0;
        w_out_wr  = 1'b0;
        if (!bus.hold) begin
            case (r_state)
                S_CLR:   w_mac_clr = 1'b1;
                S_RUN: begin
                    w_img_rd  = 1'b1;
                    w_kern_rd = 1'b1;
                end
                S_WRITE: w_out_wr = 1'b1;
                S_DONE:  w_done = 1'b1;
                default: ;
            endcase
        end
    end

    // Address arithmetic kept at full ADDR_W / KADDR_W width.
    assign w_img_addr  = (r_row + ADDR_W'(r_kr)) * IMG_W_A + r_col + ADDR_W'(r_kc);
    assign w_kern_addr = r_kr * K_A + r_kc;
    assign w_out_addr  = r_row * OUT_W_A + r_col;

    // Read data arrives one cycle after the strobe; mac_en tracks the
    // gated read strobe regardless of state so a hold bubble lines up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mac_en <= 1'b0;
        end else begin
            r_mac_en <= w_img_rd;
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.img_rd    = w_img_rd;
    assign bus.img_addr  = w_img_addr;
    assign bus.kern_rd   = w_kern_rd;
    assign bus.kern_addr = w_kern_addr;
    assign bus.mac_clr   = w_mac_clr;
    assign bus.mac_en    = r_mac_en;
    assign bus.out_wr    = w_out_wr;
    assign bus.out_addr  = w_out_addr;

endmodule

// File: tb/tb_conv_window_seq.sv
// ----------------------------------------------------------------------------
// tb_conv_window_seq
// Scoreboard bench for conv_window_seq. Instance a uses the default 28x28,
// K=3 geometry; instance b uses 12x12, K=5. Starting a pass pushes the
// expected read and write address streams; per-instance monitors pop them
// when the DUT strobes img_rd / out_wr.
// ----------------------------------------------------------------------------
module tb_conv_window_seq;

    localparam int AW = 28, AH = 28, AK = 3;
    localparam int BW = 12, BH = 12, BK = 5;

    typedef struct {
        int img;
        int kern;
    } rd_t;

    logic clk;
    logic reset_n;

    conv_window_seq_if #(.ADDR_W(10), .KADDR_W(4)) bus_a ();
    conv_window_seq_if #(.ADDR_W(10), .KADDR_W(5)) bus_b ();

    conv_window_seq #(
        .IMG_W(AW), .IMG_H(AH), .K(AK), .ADDR_W(10), .KADDR_W(4)
    ) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    conv_window_seq #(
        .IMG_W(BW), .IMG_H(BH), .K(BK), .ADDR_W(10), .KADDR_W(5)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc_cnt = 0;
    int  t0 = 0;
    bit  done_ok_a = 0;
    bit  done_ok_b = 0;

    rd_t qa_img[$];
    int  qa_out[$];
    rd_t qb_img[$];
    int  qb_out[$];
    rd_t ea;
    rd_t eb;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: raster over output pixels, kc fastest inside a window.
    function automatic void push_pass(input bit b);
        int w, h, k;
        rd_t e;
        w = b ? BW : AW;
        h = b ? BH : AH;
        k = b ? BK : AK;
        for (int r = 0; r <= h - k; r++) begin
            for (int c = 0; c <= w - k; c++) begin
                for (int kr = 0; kr < k; kr++) begin
                    for (int kc = 0; kc < k; kc++) begin
                        e.img  = (r + kr) * w + (c + kc);
                        e.kern = kr * k + kc;
                        if (b) qb_img.push_back(e); else qa_img.push_back(e);
                    end
                end
                if (b) qb_out.push_back(r * (w - k + 1) + c);
                else   qa_out.push_back(r * (w - k + 1) + c);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (bus_a.img_rd) begin
            if (qa_img.size() == 0) check("a_extra_img_rd", 1, 0);
            else begin
                ea = qa_img.pop_front();
                check("a_img_addr", bus_a.img_addr, ea.img);
                check("a_kern_addr", bus_a.kern_addr, ea.kern);
            end
        end
        if (bus_a.out_wr) begin
            if (qa_out.size() == 0) check("a_extra_out_wr", 1, 0);
            else check("a_out_addr", bus_a.out_addr, qa_out.pop_front());
        end
        if (bus_a.done && !done_ok_a) check("a_spurious_done", 1, 0);
    end

    always @(negedge clk) begin
        if (bus_b.img_rd) begin
            if (qb_img.size() == 0) check("b_extra_img_rd", 1, 0);
            else begin
                eb = qb_img.pop_front();
                check("b_img_addr", bus_b.img_addr, eb.img);
                check("b_kern_addr", bus_b.kern_addr, eb.kern);
            end
        end
        if (bus_b.out_wr) begin
            if (qb_out.size() == 0) check("b_extra_out_wr", 1, 0);
            else check("b_out_addr", bus_b.out_addr, qb_out.pop_front());
        end
        if (bus_b.done && !done_ok_b) check("b_spurious_done", 1, 0);
    end

    // Drive a one-cycle start; the cycle it is visible in is cycle 0.
    task automatic start_pass(input bit b);
        push_pass(b);
        t0 = cyc_cnt;
        if (b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
        tick();
        if (b) bus_b.start = 1'b0; else bus_a.start = 1'b0;
    endtask

    // Start in cycle 0, mac_clr in cycle 1, then (K*K+3) cycles per pixel,
    // so done lands on cycle 1 + (K*K+3)*pixels.
    task automatic wait_done(input bit b, input int exp_dt, input string tag);
        bit seen;
        seen = 0;
        if (b) done_ok_b = 1; else done_ok_a = 1;
        for (int n = 0; n < 20000 && !seen; n++) begin
            @(negedge clk);
            seen = b ? bus_b.done : bus_a.done;
        end
        if (!seen) check({tag, "_done_timeout"}, 0, 1);
        else       check({tag, "_done_cycle"}, cyc_cnt - t0, exp_dt);
        @(negedge clk);
        check({tag, "_done_width"}, b ? bus_b.done : bus_a.done, 0);
        check({tag, "_idle_after"}, b ? bus_b.busy : bus_a.busy, 0);
        check({tag, "_img_q_empty"}, b ? qb_img.size() : qa_img.size(), 0);
        check({tag, "_out_q_empty"}, b ? qb_out.size() : qa_out.size(), 0);
        if (b) done_ok_b = 0; else done_ok_a = 0;
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, "_busy"},      bus_a.busy, 0);
        check({tag, "_done"},      bus_a.done, 0);
        check({tag, "_img_rd"},    bus_a.img_rd, 0);
        check({tag, "_kern_rd"},   bus_a.kern_rd, 0);
        check({tag, "_mac_clr"},   bus_a.mac_clr, 0);
        check({tag, "_mac_en"},    bus_a.mac_en, 0);
        check({tag, "_out_wr"},    bus_a.out_wr, 0);
        check({tag, "_img_addr"},  bus_a.img_addr, 0);
        check({tag, "_kern_addr"}, bus_a.kern_addr, 0);
        check({tag, "_out_addr"},  bus_a.out_addr, 0);
    endtask

    int first_win[9];
    bit found;

    initial begin
        first_win = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
        reset_n = 1'b0;
        bus_a.start = 1'b0; bus_a.hold = 1'b0; bus_a.abort = 1'b0;
        bus_b.start = 1'b0; bus_b.hold = 1'b0; bus_b.abort = 1'b0;
        #1;
        check_all_zero_a("rst");
        check("rst_b_busy", bus_b.busy, 0);
        tick(); tick(); tick();
        reset_n = 1'b1;
        tick();

        // hold in IDLE blocks start
        bus_a.hold = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_idle_busy", bus_a.busy, 0);
            tick();
        end

        // first-pixel timing, start repeated while busy, full pass
        push_pass(0);
        t0 = cyc_cnt;
        bus_a.start = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            check("t_busy", bus_a.busy, c == 0 ? 0 : 1);
            check("t_mac_clr", bus_a.mac_clr, c == 1);
            check("t_img_rd", bus_a.img_rd, (c >= 2 && c <= 10));
            if (c >= 2 && c <= 10) check("t_img_addr", bus_a.img_addr, first_win[c - 2]);
            check("t_mac_en", bus_a.mac_en, (c >= 3 && c <= 11));
            check("t_out_wr", bus_a.out_wr, c == 12);
            if (c == 12) check("t_out_addr", bus_a.out_addr, 0);
            tick();
            if (c == 0) bus_a.start = 1'b0;
            if (c == 5) bus_a.start = 1'b1;
            if (c == 6) bus_a.start = 1'b0;
        end
        wait_done(0, 1 + (AK * AK + 3) * (AW - AK + 1) * (AH - AK + 1), "full");

        // hold for 5 cycles at kc=1 of the first window
        start_pass(0);
        tick();
        tick();
        bus_a.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_img_rd", bus_a.img_rd, 0);
            check("hold_kern_rd", bus_a.kern_rd, 0);
            check("hold_kern_addr", bus_a.kern_addr, 1);
            check("hold_img_addr", bus_a.img_addr, 1);
            check("hold_mac_en", bus_a.mac_en, i == 0);
            tick();
        end
        bus_a.hold = 1'b0;
        @(negedge clk);
        check("hold_resume_rd", bus_a.img_rd, 1);
        wait_done(0, 1 + 12 * 676 + 5, "hold");

        // abort during WRITE of pixel 100
        start_pass(0);
        found = 0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(negedge clk);
            found = bus_a.out_wr && (bus_a.out_addr == 10'd99);
        end
        check("abort_find_px99", found, 1);
        for (int i = 0; i < 12; i++) tick();
        bus_a.abort = 1'b1;
        @(negedge clk);
        check("abort_wr_px100", bus_a.out_wr, 1);
        check("abort_addr_px100", bus_a.out_addr, 100);
        tick();
        bus_a.abort = 1'b0;
        @(negedge clk);
        check("abort_idle", bus_a.busy, 0);
        qa_img.delete();
        qa_out.delete();
        for (int i = 0; i < 40; i++) tick();
        check("abort_still_idle", bus_a.busy, 0);

        // restart after abort begins again at out_addr 0
        start_pass(0);
        wait_done(0, 1 + 12 * 676, "restart");

        // reset mid-RUN
        start_pass(0);
        tick(); tick(); tick(); tick();
        #1;
        check("pre_rst_img_rd", bus_a.img_rd, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero_a("async_rst");
        qa_img.delete();
        qa_out.delete();
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        check("post_rst_busy", bus_a.busy, 0);
        tick();

        // 12x12 image, K=5
        start_pass(1);
        wait_done(1, 1 + (BK * BK + 3) * (BW - BK + 1) * (BH - BK + 1), "b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
